// File: rtl/ice_bus_target.sv
// ICE bus target: shifts in serial debug frames, executes ping/read/write/control, shifts out a 17-bit response.
// Optional ICE_BUS_PARITY_EN: 35-bit frames whose last bit is even parity over the first 34.
module ice_bus_target #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ERR_VALUE      = 16'hDEAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ICE_BUS_CMD,
  input  logic        ICE_BUS_FROMICE,
  output logic        ICE_BUS_RESP,
  output logic        ICE_BUS_TOICE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA,
  output logic        CORE_RESET,
  output logic        CORE_HALT,
  output logic [7:0]  ERR_CNT
);

`ifdef ICE_BUS_PARITY_EN
  localparam int FRAME_BITS = 35;
`else
  localparam int FRAME_BITS = 34;
`endif
  localparam logic [5:0]  LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  typedef enum logic [2:0] {IDLE, SHIFT_IN, EXEC, WAIT_ACK, SHIFT_OUT, DRAIN} state_t;
  state_t state_q, state_d;

  logic [FRAME_BITS-1:0] frame_q;
  logic [5:0]            bit_cnt_q;
  logic [15:0]           tmr_q;
  logic [16:0]           rsp_sr_q;
  logic [4:0]            rsp_cnt_q;
  logic                  req_q, we_q, resp_q, core_reset_q, core_halt_q;
  logic [15:0]           addr_q, wdata_q;
  logic [7:0]            err_cnt_q;

  logic [1:0]  f_op;
  logic [15:0] f_addr, f_data;
  logic        frame_ok, is_mem, tmr_zero;

  logic        shift_en, drop, par_err, ctrl_upd, mem_start, mem_done, rsp_load;
  logic [16:0] rsp_val;

  // Fields sit above the optional parity bit, MSB first.
  assign f_op   = frame_q[FRAME_BITS-1 -: 2];
  assign f_addr = frame_q[FRAME_BITS-3 -: 16];
  assign f_data = frame_q[FRAME_BITS-19 -: 16];

`ifdef ICE_BUS_PARITY_EN
  assign frame_ok = ~(^frame_q);
`else
  assign frame_ok = 1'b1;
`endif

  assign is_mem   = frame_ok && ((f_op == OP_READ) || (f_op == OP_WRITE));
  assign tmr_zero = (tmr_q == 16'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (ICE_BUS_CMD) state_d = SHIFT_IN;
      SHIFT_IN: begin
        if (!ICE_BUS_CMD)                state_d = IDLE;
        else if (bit_cnt_q == LAST_BIT)  state_d = EXEC;
      end
      EXEC:      state_d = is_mem ? WAIT_ACK : SHIFT_OUT;
      WAIT_ACK:  if (MEM_ACK || tmr_zero) state_d = SHIFT_OUT;
      SHIFT_OUT: if (rsp_cnt_q == 5'd0) state_d = DRAIN;
      DRAIN:     if (!ICE_BUS_CMD) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = 1'b0;
    drop      = 1'b0;
    par_err   = 1'b0;
    ctrl_upd  = 1'b0;
    mem_start = 1'b0;
    mem_done  = 1'b0;
    rsp_load  = 1'b0;
    rsp_val   = 17'd0;
    case (state_q)
      IDLE:     shift_en = ICE_BUS_CMD;
      SHIFT_IN: begin
        shift_en = ICE_BUS_CMD;
        drop     = !ICE_BUS_CMD;
      end
      EXEC: begin
        if (!frame_ok) begin
          par_err  = 1'b1;
          rsp_load = 1'b1;
          rsp_val  = {1'b1, ERR_VALUE};
        end else if (is_mem) begin
          mem_start = 1'b1;
        end else if (f_op == OP_CTRL) begin
          ctrl_upd = 1'b1;
          rsp_load = 1'b1;
          rsp_val  = {15'd0, f_data[1:0]};
        end else begin
          rsp_load = 1'b1;
          rsp_val  = {15'd0, core_halt_q, core_reset_q};
        end
      end
      // An ack in the timeout cycle still counts as success.
      WAIT_ACK: begin
        if (MEM_ACK) begin
          mem_done = 1'b1;
          rsp_load = 1'b1;
          rsp_val  = {1'b0, we_q ? wdata_q : MEM_RDATA};
        end else if (tmr_zero) begin
          mem_done = 1'b1;
          rsp_load = 1'b1;
          rsp_val  = {1'b1, ERR_VALUE};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q      <= '0;
      bit_cnt_q    <= 6'd0;
      tmr_q        <= 16'd0;
      rsp_sr_q     <= 17'd0;
      rsp_cnt_q    <= 5'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      resp_q       <= 1'b0;
      core_reset_q <= 1'b0;
      core_halt_q  <= 1'b0;
      addr_q       <= 16'd0;
      wdata_q      <= 16'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      if (shift_en) begin
        frame_q   <= {frame_q[FRAME_BITS-2:0], ICE_BUS_FROMICE};
        bit_cnt_q <= (state_q == IDLE) ? 6'd1 : bit_cnt_q + 6'd1;
      end
      if ((drop || par_err) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (ctrl_upd) begin
        core_reset_q <= f_data[0];
        core_halt_q  <= f_data[1];
      end
      if (mem_start) begin
        req_q   <= 1'b1;
        we_q    <= (f_op == OP_WRITE);
        addr_q  <= f_addr;
        wdata_q <= f_data;
        tmr_q   <= TMR_LOAD;
      end else if ((state_q == WAIT_ACK) && !tmr_zero) begin
        tmr_q <= tmr_q - 16'd1;
      end
      if (mem_done) req_q <= 1'b0;
      // Shifting zeros in leaves TOICE low once the 17th bit has gone out.
      if (rsp_load) begin
        rsp_sr_q  <= rsp_val;
        rsp_cnt_q <= 5'd16;
        resp_q    <= 1'b1;
      end else if (state_q == SHIFT_OUT) begin
        rsp_sr_q <= {rsp_sr_q[15:0], 1'b0};
        if (rsp_cnt_q == 5'd0) resp_q    <= 1'b0;
        else                   rsp_cnt_q <= rsp_cnt_q - 5'd1;
      end
    end
  end

  assign ICE_BUS_RESP  = resp_q;
  assign ICE_BUS_TOICE = rsp_sr_q[16];
  assign MEM_REQ       = req_q;
  assign MEM_WE        = we_q;
  assign MEM_ADDR      = addr_q;
  assign MEM_WDATA     = wdata_q;
  assign CORE_RESET    = core_reset_q;
  assign CORE_HALT     = core_halt_q;
  assign ERR_CNT       = err_cnt_q;

endmodule

// File: tb/tb_ice_bus_target.sv
// Directed bench for ice_bus_target: frames in, memory model with programmable ack delay, response capture.
module tb_ice_bus_target;

`ifdef ICE_BUS_PARITY_EN
  localparam int FB = 35;
`else
  localparam int FB = 34;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ICE_BUS_CMD = 1'b0;
  logic        ICE_BUS_FROMICE = 1'b0;
  logic        ICE_BUS_RESP, ICE_BUS_TOICE;
  logic        MEM_REQ, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [15:0] MEM_RDATA = 16'd0;
  logic        CORE_RESET, CORE_HALT;
  logic [7:0]  ERR_CNT;

  ice_bus_target #(.TIMEOUT_CYCLES(8), .ERR_VALUE(16'hDEAD)) dut (
    .CLK(CLK), .RST(RST),
    .ICE_BUS_CMD(ICE_BUS_CMD), .ICE_BUS_FROMICE(ICE_BUS_FROMICE),
    .ICE_BUS_RESP(ICE_BUS_RESP), .ICE_BUS_TOICE(ICE_BUS_TOICE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .CORE_RESET(CORE_RESET), .CORE_HALT(CORE_HALT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mem [logic [15:0]];
  int          ack_delay = 0;
  int          ack_cyc = 0;
  int          req_run = 0, req_last = 0, req_seen = 0, req_unstable = 0;
  logic [15:0] req_addr = 16'd0, req_wdata = 16'd0;
  logic        req_we = 1'b0;

  logic        in_rsp = 1'b0, rsp_done = 1'b0;
  logic [16:0] rsp_word = 17'd0;
  int          rsp_len = 0, rsp_runs = 0, rsp_first_cyc = 0, toice_idle_bad = 0;
  int          last_bit_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive memory inputs for the next rising edge.
  task automatic step();
    @(negedge CLK);
    cyc++;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'($urandom);
    if (MEM_REQ) begin
      if (req_run != 0 && (MEM_ADDR != req_addr || MEM_WE != req_we || MEM_WDATA != req_wdata))
        req_unstable++;
      req_run++;
      req_seen++;
      req_addr  = MEM_ADDR;
      req_we    = MEM_WE;
      req_wdata = MEM_WDATA;
      if (ack_delay != 0 && req_run == ack_delay) begin
        MEM_ACK = 1'b1;
        ack_cyc = cyc;
        if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
        else        MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 16'd0;
      end
    end else if (req_run != 0) begin
      req_last = req_run;
      req_run  = 0;
    end
    if (ICE_BUS_RESP) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        rsp_word = 17'd0;
        rsp_len = 0;
        rsp_first_cyc = cyc;
        rsp_runs++;
      end
      rsp_word = {rsp_word[15:0], ICE_BUS_TOICE};
      rsp_len++;
    end else begin
      if (in_rsp) begin
        in_rsp = 1'b0;
        rsp_done = 1'b1;
      end
      if (ICE_BUS_TOICE) toice_idle_bad++;
    end
  endtask

  task automatic clear_stats();
    req_seen = 0; req_last = 0; req_unstable = 0;
    rsp_done = 1'b0; rsp_runs = 0; rsp_len = 0; rsp_word = 17'd0;
  endtask

  function automatic logic [34:0] mk_frame(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    logic [33:0] b;
    b = {op, a, d};
`ifdef ICE_BUS_PARITY_EN
    return {b, ^b};
`else
    return {1'b0, b};
`endif
  endfunction

  task automatic send_frame(input logic [34:0] f, input int nbits, input int extra);
    for (int i = nbits - 1; i >= 0; i--) begin
      step();
      ICE_BUS_CMD = 1'b1;
      ICE_BUS_FROMICE = f[i];
    end
    last_bit_cyc = cyc;
    for (int i = 0; i < extra; i++) begin
      step();
      ICE_BUS_FROMICE = 1'($urandom);
    end
    step();
    ICE_BUS_CMD = 1'b0;
    ICE_BUS_FROMICE = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!rsp_done && n < 200) begin
      step();
      n++;
    end
    check_eq({tag, "_done"}, 32'(rsp_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] f;

    // Reset state
    repeat (3) step();
    check_eq("rst_req",   32'(MEM_REQ), 32'd0);
    check_eq("rst_resp",  32'(ICE_BUS_RESP), 32'd0);
    check_eq("rst_toice", 32'(ICE_BUS_TOICE), 32'd0);
    check_eq("rst_core",  32'({CORE_HALT, CORE_RESET}), 32'd0);
    check_eq("rst_err",   32'(ERR_CNT), 32'd0);
    check_eq("rst_addr",  32'(MEM_ADDR), 32'd0);
    RST = 1'b0;
    repeat (2) step();

    // Write 0x1234 <- 0xBEEF, ack on third request cycle
    clear_stats();
    ack_delay = 3;
    send_frame(mk_frame(2'b10, 16'h1234, 16'hBEEF), FB, 0);
    wait_resp("wr");
    check_eq("wr_req_cycles", 32'(req_last), 32'd3);
    check_eq("wr_we",     32'(req_we), 32'd1);
    check_eq("wr_addr",   32'(req_addr), 32'h1234);
    check_eq("wr_wdata",  32'(req_wdata), 32'hBEEF);
    check_eq("wr_stable", 32'(req_unstable), 32'd0);
    check_eq("wr_rsp",    32'(rsp_word), 32'h0BEEF);
    check_eq("wr_len",    32'(rsp_len), 32'd17);
    check_eq("wr_lat",    32'(rsp_first_cyc - ack_cyc), 32'd1);

    // Read back
    clear_stats();
    ack_delay = 2;
    send_frame(mk_frame(2'b01, 16'h1234, 16'h0000), FB, 0);
    wait_resp("rd");
    check_eq("rd_we",  32'(req_we), 32'd0);
    check_eq("rd_req_cycles", 32'(req_last), 32'd2);
    check_eq("rd_rsp", 32'(rsp_word), 32'h0BEEF);
    check_eq("rd_len", 32'(rsp_len), 32'd17);
    check_eq("rd_lat", 32'(rsp_first_cyc - ack_cyc), 32'd1);

    // Control frames
    clear_stats();
    send_frame(mk_frame(2'b11, 16'h0000, 16'h0003), FB, 0);
    wait_resp("ctl3");
    check_eq("ctl3_rsp",  32'(rsp_word), 32'h00003);
    check_eq("ctl3_core", 32'({CORE_HALT, CORE_RESET}), 32'd3);
    check_eq("ctl3_lat",  32'(rsp_first_cyc - last_bit_cyc), 32'd2);
    check_eq("ctl3_noreq", 32'(req_seen), 32'd0);

    clear_stats();
    send_frame(mk_frame(2'b11, 16'h0000, 16'h0000), FB, 0);
    wait_resp("ctl0");
    check_eq("ctl0_rsp",  32'(rsp_word), 32'h00000);
    check_eq("ctl0_core", 32'({CORE_HALT, CORE_RESET}), 32'd0);

    clear_stats();
    send_frame(mk_frame(2'b11, 16'hFFFF, 16'hFFFE), FB, 0);
    wait_resp("ctl2");
    check_eq("ctl2_rsp",  32'(rsp_word), 32'h00002);
    check_eq("ctl2_core", 32'({CORE_HALT, CORE_RESET}), 32'd2);

    // Timeout: no ack for 8 request cycles
    clear_stats();
    ack_delay = 0;
    send_frame(mk_frame(2'b01, 16'h0042, 16'h0000), FB, 0);
    wait_resp("tmo");
    check_eq("tmo_req_cycles", 32'(req_last), 32'd8);
    check_eq("tmo_rsp",  32'(rsp_word), 32'h1DEAD);
    check_eq("tmo_len",  32'(rsp_len), 32'd17);

    // Ack in the same cycle as the timeout wins
    clear_stats();
    ack_delay = 8;
    send_frame(mk_frame(2'b01, 16'h1234, 16'h0000), FB, 0);
    wait_resp("tmoack");
    check_eq("tmoack_req_cycles", 32'(req_last), 32'd8);
    check_eq("tmoack_rsp", 32'(rsp_word), 32'h0BEEF);

    // Short frame dropped, then ping
    clear_stats();
    send_frame(mk_frame(2'b10, 16'h5555, 16'h1111), 20, 0);
    repeat (30) step();
    check_eq("short_noresp", 32'(rsp_runs), 32'd0);
    check_eq("short_noreq",  32'(req_seen), 32'd0);
    check_eq("short_err",    32'(ERR_CNT), 32'd1);
    clear_stats();
    send_frame(mk_frame(2'b00, 16'h0000, 16'h0000), FB, 0);
    wait_resp("ping");
    check_eq("ping_rsp", 32'(rsp_word), 32'h00002);
    check_eq("ping_err", 32'(ERR_CNT), 32'd1);

    // CMD held 40 cycles: one execution only
    clear_stats();
    send_frame(mk_frame(2'b00, 16'hABCD, 16'h1234), FB, 40 - FB);
    wait_resp("long");
    repeat (10) step();
    check_eq("long_runs", 32'(rsp_runs), 32'd1);
    check_eq("long_rsp",  32'(rsp_word), 32'h00002);
    check_eq("long_noreq", 32'(req_seen), 32'd0);

    // CMD held through the response, 1-cycle low gap, then a write
    clear_stats();
    send_frame(mk_frame(2'b00, 16'h0000, 16'h0000), FB, 24);
    check_eq("b2b1_done", 32'(rsp_done), 32'd1);
    check_eq("b2b1_rsp",  32'(rsp_word), 32'h00002);
    clear_stats();
    ack_delay = 1;
    send_frame(mk_frame(2'b10, 16'h0010, 16'h5A5A), FB, 0);
    wait_resp("b2b2");
    check_eq("b2b2_rsp",  32'(rsp_word), 32'h05A5A);
    check_eq("b2b2_addr", 32'(req_addr), 32'h0010);
    check_eq("b2b2_req_cycles", 32'(req_last), 32'd1);
    check_eq("b2b2_err",  32'(ERR_CNT), 32'd1);

`ifdef ICE_BUS_PARITY_EN
    clear_stats();
    f = mk_frame(2'b00, 16'h0000, 16'h0000);
    f[0] = ~f[0];
    send_frame(f, FB, 0);
    wait_resp("par_bad");
    check_eq("par_bad_rsp", 32'(rsp_word), 32'h1DEAD);
    check_eq("par_bad_err", 32'(ERR_CNT), 32'd2);
    check_eq("par_bad_noreq", 32'(req_seen), 32'd0);
    clear_stats();
    send_frame(mk_frame(2'b00, 16'h0000, 16'h0000), FB, 0);
    wait_resp("par_ok");
    check_eq("par_ok_rsp", 32'(rsp_word), 32'h00002);
`endif

    // ERR_CNT saturates
    f = mk_frame(2'b01, 16'h0000, 16'h0000);
    for (int i = 0; i < 300; i++) send_frame(f, 2, 0);
    step();
    check_eq("err_sat", 32'(ERR_CNT), 32'd255);

    // Reset during WAIT_ACK
    clear_stats();
    ack_delay = 0;
    send_frame(mk_frame(2'b01, 16'h0F00, 16'h0000), FB, 0);
    for (int n = 0; n < 10 && req_run < 2; n++) step();
    check_eq("mid_req_pre",  32'(MEM_REQ), 32'd1);
    check_eq("mid_halt_pre", 32'(CORE_HALT), 32'd1);
    #1 RST = 1'b1;
    #1;
    check_eq("mid_req",  32'(MEM_REQ), 32'd0);
    check_eq("mid_resp", 32'(ICE_BUS_RESP), 32'd0);
    check_eq("mid_core", 32'({CORE_HALT, CORE_RESET}), 32'd0);
    check_eq("mid_err",  32'(ERR_CNT), 32'd0);
    check_eq("mid_addr", 32'(MEM_ADDR), 32'd0);
    repeat (2) step();
    RST = 1'b0;
    clear_stats();
    repeat (12) step();
    check_eq("mid_after_req",  32'(req_seen), 32'd0);
    check_eq("mid_after_resp", 32'(rsp_runs), 32'd0);
    check_eq("toice_idle", 32'(toice_idle_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
